uart_rx: RTL and testbench

Oversampling UART receiver: the receive-side counterpart of the team's UART transmitter, sharing its frame format (1 start bit = 0, 8 data bits LSB first, optional parity, 1 stop bit = 1). It recovers bytes from the asynchronous `RX_IN` line using a programmable oversampling ratio and 3-sample majority voting. It delivers each good byte on `P_DATA` with a one-cycle `data_valid` pulse, and flags parity and stop-bit errors. It sits in the UART block beside the transmitter, driven by the RX-side oversampling clock.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start, DATA_WIDTH data bits LSB first,
// optional parity, 1 stop; 3-sample majority vote around mid-bit.
//
// Ports:
//   CLK        oversampling clock, rising edge
//   rst        asynchronous active-high reset
//   RX_IN      serial line (idle high, already synchronised)
//   Prescale   clocks per bit (8, 16 or 32), latched at frame start
//   PAR_EN     frame carries a parity bit, latched at frame start
//   PAR_TYP    0 = even, 1 = odd parity, latched at frame start
//   P_DATA     last good byte, held between frames
//   data_valid one-cycle pulse when P_DATA is updated
//   par_err    one-cycle pulse on parity mismatch
//   stp_err    one-cycle pulse on stop-bit error
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT =
    BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE =
    PRESCALE_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [PRESCALE_W-1:0]   p_lat;
  logic                    par_en_lat;
  logic                    par_typ_lat;
  logic                    s0;
  logic                    s1;
  logic                    s2;
  logic [DATA_WIDTH-1:0]   shadow;
  logic                    par_bad;

  logic [PRESCALE_W-1:0]   half;
  logic                    is_last;
  logic                    at_s0;
  logic                    at_s1;
  logic                    at_s2;
  logic                    sampled;
  logic                    exp_par;

  assign half    = p_lat >> 1;
  assign is_last = (edge_cnt == p_lat - ONE);
  assign at_s0   = (edge_cnt == half - ONE);
  assign at_s1   = (edge_cnt == half);
  assign at_s2   = (edge_cnt == half + ONE);

  // Majority of the three mid-bit samples; settled from edge P/2+2.
  assign sampled = (s0 & s1) | (s0 & s2) | (s1 & s2);

  // Even parity expects XOR of data, odd expects its complement.
  assign exp_par = (^shadow) ^ par_typ_lat;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      p_lat       <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      s2          <= 1'b1;
      shadow      <= '0;
      par_bad     <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state != IDLE) begin
        if (at_s0) s0 <= RX_IN;
        if (at_s1) s1 <= RX_IN;
        if (at_s2) s2 <= RX_IN;
        edge_cnt <= is_last ? '0 : edge_cnt + ONE;
      end

      unique case (state)
        IDLE: begin
          // Detection cycle is edge 0 of the start bit.
          if (!RX_IN) begin
            state       <= START;
            edge_cnt    <= ONE;
            bit_cnt     <= '0;
            par_bad     <= 1'b0;
            p_lat       <= Prescale;
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
          end
        end

        START: begin
          if (is_last) begin
            bit_cnt <= '0;
            state   <= sampled ? IDLE : DATA;
          end
        end

        DATA: begin
          if (is_last) begin
            shadow  <= {sampled, shadow[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= par_en_lat ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (is_last) begin
            if (sampled != exp_par) begin
              par_err <= 1'b1;
              par_bad <= 1'b1;
            end
            state <= STOP;
          end
        end

        STOP: begin
          if (is_last) begin
            if (!sampled) begin
              stp_err <= 1'b1;
            end else if (!par_bad) begin
              P_DATA     <= shadow;
              data_valid <= 1'b1;
            end
            // Line already low: this cycle is edge 0 of the next start.
            if (!RX_IN) begin
              state       <= START;
              edge_cnt    <= ONE;
              bit_cnt     <= '0;
              par_bad     <= 1'b0;
              p_lat       <= Prescale;
              par_en_lat  <= PAR_EN;
              par_typ_lat <= PAR_TYP;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// Drives frames bit by bit and checks pulse timing and data.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int k;
  int dv_n, pe_n, se_n;
  int dv_at, pe_at, se_at, dv_abs;
  logic [7:0] dv_data;
  int t1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    k = 0;
    dv_n = 0; pe_n = 0; se_n = 0;
    dv_at = -1; pe_at = -1; se_at = -1;
    dv_data = 8'hxx;
  endtask

  task automatic tick(input logic v);
    @(negedge CLK);
    RX_IN = v;
    @(posedge CLK);
    #1;
    if (data_valid === 1'b1) begin
      dv_n++; dv_at = k; dv_data = P_DATA; dv_abs = cyc;
    end
    if (par_err === 1'b1) begin
      pe_n++; pe_at = k;
    end
    if (stp_err === 1'b1) begin
      se_n++; se_at = k;
    end
    k++;
  endtask

  task automatic send_bit(input logic v, input int p, input int inv);
    for (int c = 0; c < p; c++) tick((c == inv) ? ~v : v);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p,
                            input logic pe, input logic pb,
                            input logic sb, input int inv);
    clr();
    send_bit(1'b0, p, inv);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, inv);
    if (pe) send_bit(pb, p, inv);
    send_bit(sb, p, inv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    RX_IN = 1'b1;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    clr();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pdata", P_DATA, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_pe", par_err, 0);
    chk("rst_se", stp_err, 0);
    @(negedge CLK);
    rst = 1'b0;
    idle(4);

    // Basic frame, P=8, no parity
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    chk("a5_dv_n", dv_n, 1);
    chk("a5_dv_at", dv_at, 79);
    chk("a5_data", dv_data, 8'hA5);
    chk("a5_pe_n", pe_n, 0);
    chk("a5_se_n", se_n, 0);
    clr();
    idle(20);
    chk("a5_quiet", dv_n + pe_n + se_n, 0);
    chk("a5_hold", P_DATA, 8'hA5);

    // Even parity, P=16
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
    chk("ev_dv_n", dv_n, 1);
    chk("ev_dv_at", dv_at, 175);
    chk("ev_data", dv_data, 8'h3C);
    chk("ev_pe_n", pe_n, 0);
    idle(10);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
    chk("evbad_pe_n", pe_n, 1);
    chk("evbad_pe_at", pe_at, 159);
    chk("evbad_dv_n", dv_n, 0);
    chk("evbad_se_n", se_n, 0);
    chk("evbad_hold", P_DATA, 8'h3C);
    idle(10);

    // Stop error, P=32, odd parity (expected parity of 0x01 is 0)
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, -1);
    chk("stp_se_n", se_n, 1);
    chk("stp_se_at", se_at, 351);
    chk("stp_dv_n", dv_n, 0);
    chk("stp_pe_n", pe_n, 0);
    clr();
    idle(40);
    chk("stp_quiet", dv_n + pe_n + se_n, 0);
    chk("stp_hold", P_DATA, 8'h3C);

    // Start glitch, then a frame starting exactly P cycles later
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clr();
    tick(1'b0);
    tick(1'b0);
    idle(6);
    chk("glitch_quiet", dv_n + pe_n + se_n, 0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 4);
    chk("maj_dv_n", dv_n, 1);
    chk("maj_dv_at", dv_at, 79);
    chk("maj_data", dv_data, 8'h55);
    chk("maj_err", pe_n + se_n, 0);
    idle(5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, -1);
    chk("b2b0_dv_n", dv_n, 1);
    chk("b2b0_data", dv_data, 8'h00);
    t1 = dv_abs;
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1);
    chk("b2b1_dv_n", dv_n, 1);
    chk("b2b1_data", dv_data, 8'hFF);
    chk("b2b_gap", dv_abs - t1, 80);
    idle(5);

    // Reset during data bit 4 of 0x96
    clr();
    send_bit(1'b0, 8, -1);
    for (int i = 0; i < 4; i++) send_bit(((8'h96 >> i) & 1) != 0, 8, -1);
    tick(1'b1);
    tick(1'b1);
    @(negedge CLK);
    rst = 1'b1;
    #1;
    chk("mid_pdata", P_DATA, 0);
    chk("mid_dv", data_valid, 0);
    chk("mid_pe", par_err, 0);
    chk("mid_se", stp_err, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    RX_IN = 1'b1;
    clr();
    idle(20);
    chk("mid_quiet", dv_n + pe_n + se_n, 0);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1);
    chk("post_dv_n", dv_n, 1);
    chk("post_dv_at", dv_at, 79);
    chk("post_data", dv_data, 8'h12);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
